event_demux: RTL



---
 rtl/event_pkg.sv | 10 +
 rtl/event_demux_skid.sv | 57 +++++
 rtl/event_demux.sv | 92 +++++++++
 3 files changed

// File: rtl/event_pkg.sv
// event_pkg: default event field widths and select-width helper shared by the event mux and demux
package event_pkg;
   localparam int QUEUE_INDEX_WIDTH_DEF  = 4;
   localparam int FUNCTION_ID_WIDTH_DEF  = 8;
   localparam int EVENT_TYPE_WIDTH_DEF   = 16;
   localparam int EVENT_SOURCE_WIDTH_DEF = 16;
   function automatic int sel_width(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction
endpackage

// File: rtl/event_demux_skid.sv
// event_demux_skid: two-entry per-port register slice with a registered internal ready
module event_demux_skid #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr,
   input  logic [W-1:0] wr_data,
   input  logic         m_ready,
   output logic         m_valid,
   output logic [W-1:0] m_data,
   output logic         rdy_int
);
   logic         m_valid_q, m_valid_d, temp_valid_q, temp_valid_d, rdy_q, rdy_d;
   logic [W-1:0] m_data_q, m_data_d, temp_q, temp_d;
   // a write lands in the output register when it is free or draining, else in temp; temp refills the output on ready
   always_comb begin
      rdy_d        = m_ready | (~temp_valid_q & ~m_valid_q);
      m_valid_d    = m_valid_q;
      temp_valid_d = temp_valid_q;
      m_data_d     = m_data_q;
      temp_d       = temp_q;
      if (wr) begin
         if (m_ready | ~m_valid_q) begin
            m_valid_d = 1'b1;
            m_data_d  = wr_data;
         end else begin
            temp_valid_d = 1'b1;
            temp_d       = wr_data;
         end
      end else if (m_ready) begin
         m_valid_d    = temp_valid_q;
         m_data_d     = temp_q;
         temp_valid_d = 1'b0;
      end
   end
   // control flops are reset so no partial output survives a reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q    <= 1'b0;
         temp_valid_q <= 1'b0;
         rdy_q        <= 1'b0;
      end else begin
         m_valid_q    <= m_valid_d;
         temp_valid_q <= temp_valid_d;
         rdy_q        <= rdy_d;
      end
   end
   // data registers carry no reset
   always_ff @(posedge clk) begin
      m_data_q <= m_data_d;
      temp_q   <= temp_d;
   end
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign rdy_int = rdy_q;
endmodule

// File: rtl/event_demux.sv
// event_demux: routes one event stream to PORTS outputs by select index; out-of-range selects are dropped.
// Optional EVENT_DEMUX_DROP_COUNT_EN adds a saturating 32-bit drop_count output.
module event_demux
   import event_pkg::*;
#(
   parameter int PORTS              = 2,
   parameter int QUEUE_INDEX_WIDTH  = QUEUE_INDEX_WIDTH_DEF,
   parameter int FUNCTION_ID_WIDTH  = FUNCTION_ID_WIDTH_DEF,
   parameter int EVENT_TYPE_WIDTH   = EVENT_TYPE_WIDTH_DEF,
   parameter int EVENT_SOURCE_WIDTH = EVENT_SOURCE_WIDTH_DEF,
   localparam int SEL_WIDTH         = sel_width(PORTS)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [QUEUE_INDEX_WIDTH-1:0]        s_axis_event_queue,
   input  logic [FUNCTION_ID_WIDTH-1:0]        s_axis_event_function_id,
   input  logic [EVENT_TYPE_WIDTH-1:0]         s_axis_event_type,
   input  logic [EVENT_SOURCE_WIDTH-1:0]       s_axis_event_source,
   input  logic [SEL_WIDTH-1:0]                s_axis_event_select,
   input  logic                                s_axis_event_valid,
   output logic                                s_axis_event_ready,
   output logic [PORTS*QUEUE_INDEX_WIDTH-1:0]  m_axis_event_queue,
   output logic [PORTS*FUNCTION_ID_WIDTH-1:0]  m_axis_event_function_id,
   output logic [PORTS*EVENT_TYPE_WIDTH-1:0]   m_axis_event_type,
   output logic [PORTS*EVENT_SOURCE_WIDTH-1:0] m_axis_event_source,
   output logic [PORTS-1:0]                    m_axis_event_valid,
   input  logic [PORTS-1:0]                    m_axis_event_ready
`ifdef EVENT_DEMUX_DROP_COUNT_EN
   ,
   output logic [31:0]                         drop_count
`endif
);
   localparam int QW = QUEUE_INDEX_WIDTH;
   localparam int FW = FUNCTION_ID_WIDTH;
   localparam int TW = EVENT_TYPE_WIDTH;
   localparam int SW = EVENT_SOURCE_WIDTH;
   localparam int DW = QW + FW + TW + SW;
   localparam int SP = 2 ** SEL_WIDTH;
   logic                 in_valid_q, in_valid_d, drop, fwd, hs;
   logic [DW-1:0]        in_data_q, in_data_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic [PORTS-1:0]     rdy_int, wr;
   logic [SP-1:0]        rdy_pad;
   // input stage and select decode; the ready vector is padded so out-of-range selects index safely
   always_comb begin
      rdy_pad            = SP'(rdy_int);
      drop               = {1'b0, sel_q} >= (SEL_WIDTH + 1)'(PORTS);
      fwd                = in_valid_q & (drop | rdy_pad[sel_q]);
      s_axis_event_ready = rst_n & (~in_valid_q | fwd);
      hs                 = s_axis_event_valid & s_axis_event_ready;
      in_valid_d         = hs | (in_valid_q & ~fwd);
      in_data_d          = hs ? {s_axis_event_queue, s_axis_event_function_id, s_axis_event_type, s_axis_event_source} : in_data_q;
      sel_d              = hs ? s_axis_event_select : sel_q;
      wr                 = (fwd & ~drop) ? PORTS'(1) << sel_q : '0;
   end
   // input valid flop, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_valid_q <= 1'b0;
      else        in_valid_q <= in_valid_d;
   end
   // input data and select registers carry no reset
   always_ff @(posedge clk) begin
      in_data_q <= in_data_d;
      sel_q     <= sel_d;
   end
   for (genvar i = 0; i < PORTS; i++) begin : g_port
      logic [DW-1:0] m_data;
      event_demux_skid #(.W(DW)) u_skid (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr      (wr[i]),
         .wr_data (in_data_q),
         .m_ready (m_axis_event_ready[i]),
         .m_valid (m_axis_event_valid[i]),
         .m_data  (m_data),
         .rdy_int (rdy_int[i])
      );
      assign {m_axis_event_queue[i*QW +: QW], m_axis_event_function_id[i*FW +: FW],
              m_axis_event_type[i*TW +: TW], m_axis_event_source[i*SW +: SW]} = m_data;
   end
`ifdef EVENT_DEMUX_DROP_COUNT_EN
   logic [31:0] drop_count_q, drop_count_d;
   // saturating count of discarded events
   always_comb drop_count_d = (fwd & drop & ~&drop_count_q) ? drop_count_q + 32'd1 : drop_count_q;
   // drop counter flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_count_q <= '0;
      else        drop_count_q <= drop_count_d;
   end
   assign drop_count = drop_count_q;
`endif
endmodule
